ps2_kb_receiver: RTL

PS/2 keyboard front end that sits directly upstream of the IO module's keyboard byte input.
- Samples the asynchronous KB_Clk/KB_Data lines in the Fast_Clock domain.
- Deframes 11-bit device-to-host frames and checks odd parity.
- Buffers validated scan-code bytes in a small show-ahead FIFO that the IO module pops when a keyboard-read instruction retires.

---
 rtl/kb_pkg.sv | 21 ++
 rtl/kb_fifo.sv | 81 ++++++++
 rtl/ps2_kb_receiver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/kb_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
// Latency: none (declarations only).
// Backpressure: n/a.
package kb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] KB_BREAK_CODE = 8'hF0;
  localparam logic [7:0] KB_EXT_CODE   = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
    return ^{data, p};
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// Synchronous show-ahead FIFO; head/count/full/empty are registered from next state.
// Latency: a push is visible on head the cycle after the write edge; a pop shows the new head next cycle.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = 1;
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW:0]    CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Next-state: accept a push when not full or when a pop frees the slot this cycle.
  always_comb begin
    do_pop  = pop && !empty_q;
    do_push = push && (!full_q || do_pop);
    wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    // When the new head is the slot being written this cycle, bypass the array.
    if (cnt_d == '0)
      head_d = '0;
    else if (do_push && (rd_d == wr_q))
      head_d = wdat;
    else
      head_d = mem_q[rd_d];
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= wdat;
  end

  // Pointers, fill level and registered status/head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  assign head  = head_q;
  assign count = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: synchronise, deframe 11-bit frames, check parity, buffer bytes. Optional macro KB_BREAK_FILTER_EN drops F0 and the code after it.
// Latency: byte written the cycle after the stop-bit edge is seen; visible on Kb_Byte/Byte_Valid one cycle later.
// Backpressure: none toward the keyboard; a byte arriving while the FIFO is full (and no Pop) is dropped and sets Overflow.
module ps2_kb_receiver
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                        Fast_Clock,
  input  logic                        Reset,
  input  logic                        KB_Clk,
  input  logic                        KB_Data,
  input  logic                        Pop,
  input  logic                        Clear_Err,
  output logic [7:0]                  Kb_Byte,
  output logic                        Byte_Valid,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Overflow,
  output logic                        Frame_Err
);

  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = 1;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   kb_clk_s, kb_dat_s, fall;

  rx_state_t  state_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic [TW-1:0] tmo_q;
  logic       frame_err_q;
  logic       push_q;
  logic [7:0] push_dat_q;
  logic       overflow_q;
`ifdef KB_BREAK_FILTER_EN
  logic       skip_q;
`endif

  logic fifo_full, fifo_empty, drop;

  assign kb_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign kb_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall     = clk_prev_q && !kb_clk_s;

  // Input synchronisers and previous-clock register; idle bus reads as high.
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], KB_Clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], KB_Data};
      clk_prev_q <= kb_clk_s;
    end
  end

  // Deframer FSM with inactivity timeout; error and push requests are single-cycle.
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_dat_q  <= '0;
`ifdef KB_BREAK_FILTER_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (!kb_dat_s) begin
              state_q <= DATA;
              bit_q   <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= {kb_dat_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= kb_dat_s;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (kb_dat_s && odd_parity_ok(shift_q, par_q)) begin
`ifdef KB_BREAK_FILTER_EN
              // Break prefix arms skip; the released code that follows is swallowed.
              if (skip_q) begin
                skip_q <= 1'b0;
              end else if (shift_q == KB_BREAK_CODE) begin
                skip_q <= 1'b1;
              end else begin
                push_q     <= 1'b1;
                push_dat_q <= shift_q;
              end
`else
              push_q     <= 1'b1;
              push_dat_q <= shift_q;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (tmo_q == TMO_LAST) begin
          state_q     <= IDLE;
          frame_err_q <= 1'b1;
          tmo_q       <= '0;
`ifdef KB_BREAK_FILTER_EN
          skip_q      <= 1'b0;
`endif
        end else begin
          tmo_q <= tmo_q + TMO_ONE;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  // A full FIFO still accepts a push if the consumer pops in the same cycle.
  assign drop = push_q && fifo_full && !Pop;

  // Sticky overflow; a drop in the same cycle as Clear_Err keeps it set.
  always_ff @(posedge Fast_Clock) begin
    if (Reset)
      overflow_q <= 1'b0;
    else if (drop)
      overflow_q <= 1'b1;
    else if (Clear_Err)
      overflow_q <= 1'b0;
  end

  kb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (Fast_Clock),
    .rst   (Reset),
    .push  (push_q),
    .wdat  (push_dat_q),
    .pop   (Pop),
    .head  (Kb_Byte),
    .count (Count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Byte_Valid = !fifo_empty;
  assign Overflow   = overflow_q;
  assign Frame_Err  = frame_err_q;

endmodule
